muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit (RV32M-style op set), one operation in flight.
// Multiply completes in 2 cycles; divide restores one quotient bit per cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             ACLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and out_* stay stable while out_valid is high.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  localparam int CW = $clog2(XLEN + 2);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state, w_next;

  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_a, r_b;
  logic [TAG_W-1:0] r_tag;
  logic [CW-1:0]    r_cnt;
  logic             r_fast, r_qneg, r_rneg;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]  r_rem, r_quo, r_dvsr, r_res, r_out;

  logic w_accept, w_last;
  logic w_sdiv, w_a_neg, w_b_neg, w_b_zero, w_ovf;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_fast_res;
  logic w_sa, w_sb;
  logic [2*XLEN-1:0] w_a_ext, w_b_ext, w_prod;
  logic [XLEN-1:0] w_mul_sel;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_q_fin, w_r_fin;

  assign in_ready   = (r_state == S_IDLE) && !flush;
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_result = r_out;
  assign out_tag    = r_tag;
  assign dbg_state  = r_state;

  // Divide setup works on magnitudes; signed ops are DIV (4) and REM (6).
  assign w_sdiv     = in_op[2] && !in_op[0];
  assign w_a_neg    = w_sdiv && in_a[XLEN-1];
  assign w_b_neg    = w_sdiv && in_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -in_a : in_a;
  assign w_b_mag    = w_b_neg ? -in_b : in_b;
  assign w_b_zero   = (in_b == '0);
  assign w_ovf      = w_sdiv && (in_a == MINV) && (in_b == '1);
  assign w_fast_res = w_b_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : in_a);

  assign w_sa      = (r_op == 3'd1) || (r_op == 3'd2);
  assign w_sb      = (r_op == 3'd1);
  assign w_a_ext   = {{XLEN{w_sa && r_a[XLEN-1]}}, r_a};
  assign w_b_ext   = {{XLEN{w_sb && r_b[XLEN-1]}}, r_b};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_sel = (r_op == 3'd0) ? r_prod[XLEN-1:0] : r_prod[2*XLEN-1:XLEN];

  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvsr};
  assign w_ge     = !w_diff[XLEN];
  assign w_q_fin  = r_qneg ? -r_quo : r_quo;
  assign w_r_fin  = r_rneg ? -r_rem : r_rem;

  always_comb begin
    w_last = 1'b0;
    if (r_state == S_MUL)      w_last = (r_cnt == CW'(1));
    else if (r_state == S_DIV) w_last = r_fast ? (r_cnt == CW'(1)) : (r_cnt == CW'(XLEN + 1));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = in_op[2] ? S_DIV : S_MUL;
      S_MUL, S_DIV: begin
        if (flush)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: if (flush || out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge ACLK) begin
    if (RESET) begin
      r_op <= '0; r_a <= '0; r_b <= '0; r_tag <= '0; r_cnt <= '0;
      r_fast <= 1'b0; r_qneg <= 1'b0; r_rneg <= 1'b0; r_prod <= '0;
      r_rem <= '0; r_quo <= '0; r_dvsr <= '0; r_res <= '0; r_out <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= in_op;
        r_a    <= in_a;
        r_b    <= in_b;
        r_tag  <= in_tag;
        r_cnt  <= '0;
        r_quo  <= w_a_mag;
        r_dvsr <= w_b_mag;
        r_rem  <= '0;
        r_qneg <= !in_op[1] && (w_a_neg ^ w_b_neg);
        r_rneg <= in_op[1] && w_a_neg;
        r_fast <= w_b_zero || w_ovf;
        r_res  <= w_fast_res;
      end
      if (r_state == S_MUL || r_state == S_DIV) r_cnt <= r_cnt + CW'(1);
      if (r_state == S_MUL && r_cnt == '0) r_prod <= w_prod;
      if (r_state == S_DIV && !r_fast) begin
        if (r_cnt < CW'(XLEN)) begin
          r_rem <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
        end else if (r_cnt == CW'(XLEN)) begin
          r_res <= r_op[1] ? w_r_fin : w_q_fin;
        end
      end
      // Result register only loads on entry to DONE, so it holds through the handshake.
      if (r_state != S_DONE && w_next == S_DONE)
        r_out <= (r_state == S_MUL) ? w_mul_sel : r_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected result/tag/cycle,
// monitor pops on every out_valid and also checks hold stability.
module tb_muldiv_unit;
  logic        ACLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;
  logic [1:0]  dbg_state;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .ACLK(ACLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [4:0]  exp_tag_q[$];
  int          exp_cyc_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit stall    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa = $signed(a); sb = $signed(b);
    ua = {32'b0, a}; ub = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return $urandom_range(0, 20);
      2: return 32'h0;
      3: return 32'hFFFF_FFFF - $urandom_range(0, 20);
      default: return 32'h8000_0000;
    endcase
  endfunction

  // Driver: waits (bounded) for in_ready, presents one request for one edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit push, input logic [31:0] exp_res, input int lat);
    int guard = 0;
    @(negedge ACLK);
    while (!in_ready && guard < 200) begin @(negedge ACLK); guard++; end
    if (!in_ready) begin check("accept_timeout", 0, 1); return; end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    if (push) begin
      exp_q.push_back(exp_res);
      exp_tag_q.push_back(tag);
      exp_cyc_q.push_back(cyc + 1 + lat);
    end
    @(negedge ACLK);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
  endtask

  task automatic issue_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] exp_res, input int lat);
    issue(op, a, b, tag, 1'b1, exp_res, lat);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 300) begin @(negedge ACLK); guard++; end
    if (exp_q.size() != 0 || busy) check("drain_timeout", 0, 1);
  endtask

  // Monitor: compares each new result, then checks it stays put until the handshake.
  initial begin : monitor
    bit seen = 0;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    out_ready = 1'b0;
    forever begin
      @(negedge ACLK);
      if (RESET) begin
        seen = 0; out_ready = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
          else begin
            check("result", out_result, exp_q.pop_front());
            check("tag", out_tag, exp_tag_q.pop_front());
            check("latency_cycle", cyc, exp_cyc_q.pop_front());
          end
          seen = 1; held_res = out_result; held_tag = out_tag;
        end else begin
          check("hold_result", out_result, held_res);
          check("hold_tag", out_tag, held_tag);
        end
        out_ready = !stall;
      end else begin
        seen = 0;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [2:0] op;
    logic [31:0] a, b;
    int guard;
    RESET = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0; flush = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", out_result, 0);
    check("rst_tag", out_tag, 0);
    RESET = 1'b0;
    @(negedge ACLK);
    check("rst_in_ready", in_ready, 1);

    // Multiply high variants, divide, remainder, and the fast-path corner cases.
    issue_exp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 2);
    issue_exp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2);
    issue_exp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 2);
    issue_exp(3'd0, 32'h0001_0003, 32'h0000_0005, 5'd4, 32'h0005_000F, 2);
    issue_exp(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5, 32'hFFFF_FFFD, 34);
    issue_exp(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFF, 34);
    issue_exp(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 34);
    issue_exp(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 34);
    issue_exp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 2);
    issue_exp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 2);
    issue_exp(3'd5, 32'h0, 32'h0, 5'd11, 32'hFFFF_FFFF, 2);
    issue_exp(3'd7, 32'd5, 32'h0, 5'd12, 32'd5, 2);
    issue_exp(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'd1, 34);
    wait_drain();

    // Consumer stalls for 10 cycles: result held, new requests refused.
    stall = 1;
    issue_exp(3'd0, 32'h0000_1234, 32'h0000_0010, 5'd21, 32'h0001_2340, 2);
    guard = 0;
    while (!out_valid && guard < 20) begin @(negedge ACLK); guard++; end
    check("stall_reached_done", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      check("stall_in_ready", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1)); in_op = 3'd0; in_a = $urandom; in_b = $urandom; in_tag = 5'd7;
    end
    in_valid = 1'b0;
    stall = 0;
    wait_drain();

    // Flush five cycles into a divide: nothing delivered, then a fresh multiply.
    issue(3'd5, 32'd1000, 32'd3, 5'd14, 1'b0, 32'h0, 0);
    repeat (4) @(negedge ACLK);
    flush = 1'b1;
    @(negedge ACLK);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_tag = 5'd15;
    check("flush_blocks_ready", in_ready, 0);
    @(negedge ACLK);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_blocks_accept", busy, 0);
    repeat (40) @(negedge ACLK);
    issue_exp(3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 2);
    wait_drain();

    // Reset in the middle of a divide drops it.
    issue(3'd4, 32'd12345, 32'd17, 5'd16, 1'b0, 32'h0, 0);
    repeat (10) @(negedge ACLK);
    RESET = 1'b1;
    @(negedge ACLK);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", out_result, 0);
    check("midrst_tag", out_tag, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state, 0);
    RESET = 1'b0;
    @(negedge ACLK);
    check("midrst_in_ready", in_ready, 1);
    repeat (40) @(negedge ACLK);

    // Mixed sequence against the reference model, corner operands favoured.
    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      a = rand_opnd();
      b = rand_opnd();
      issue_exp(op, a, b, 5'(n), ref_res(op, a, b), ref_lat(op, a, b));
    end
    wait_drain();
    repeat (5) @(negedge ACLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
